// File: rtl/noc_params.sv
// Shared NoC parameters.
// Holds the port count, the port index type and the flit label encoding
// from which each input port derives its is_tail flag.
package noc_params;

  localparam int unsigned PORT_NUM = 5;
  localparam int unsigned PORT_W   = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  typedef logic [PORT_W-1:0] port_t;

  typedef enum logic [1:0] {
    FlitHead     = 2'd0,
    FlitBody     = 2'd1,
    FlitTail     = 2'd2,
    FlitHeadTail = 2'd3
  } flit_label_t;

  // A flit closes its packet when it is a tail or a single-flit packet.
  function automatic logic label_is_tail(flit_label_t label);
    return (label == FlitTail) || (label == FlitHeadTail);
  endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with an owned priority pointer.
// Ports:
//   clk, rst     - clock, synchronous active-high reset (pointer -> 0)
//   request_i    - one request bit per requester
//   update_i     - advance the pointer past the winner at the next edge
//   grant_o      - one-hot grant (all zero when nobody requests)
//   grant_idx_o  - index of the granted requester (0 when no grant)
module round_robin_arbiter #(
  parameter int unsigned N    = 5,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    request_i,
  input  logic            update_i,
  output logic [N-1:0]    grant_o,
  output logic [IdxW-1:0] grant_idx_o
);

  logic [IdxW-1:0] r_ptr;
  logic [IdxW-1:0] w_ptr_next;
  logic [IdxW-1:0] w_sel;
  logic            w_found;
  int unsigned     w_cand;

  // Search ptr, ptr+1, ... modulo N; first requester wins.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    w_found     = 1'b0;
    w_cand      = 0;
    w_sel       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = 32'(r_ptr) + k;
      if (w_cand >= N) w_cand = w_cand - N;
      w_sel = IdxW'(w_cand);
      if (!w_found && request_i[w_sel]) begin
        grant_o[w_sel] = 1'b1;
        grant_idx_o    = w_sel;
        w_found        = 1'b1;
      end
    end
  end

  // Explicit wrap: N need not be a power of two.
  always_comb begin
    w_ptr_next = r_ptr;
    if (update_i && w_found) begin
      w_ptr_next = (grant_idx_o == IdxW'(N - 1)) ? '0 : grant_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_ptr <= '0;
    else     r_ptr <= w_ptr_next;
  end

endmodule

// File: rtl/switch_allocator.sv
// Separable single-cycle switch allocator.
// One round-robin arbiter per output picks at most one input per cycle;
// grants are OR-reduced back to the inputs and returned to the crossbar.
// Optional feature: define SA_WORMHOLE_LOCK_EN to keep an output locked to
// one input from a head flit until its tail flit.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   request_i    - per-input switch request
//   out_port_i   - per-input requested output (>= PORT_NUM matches nothing)
//   is_tail_i    - per-input head-of-buffer flit is tail/head-tail
//   on_off_i     - per-output downstream may accept
//   valid_o      - per-input grant (buffer read strobe)
//   xb_sel_o     - per-output selected input index (0 when idle)
//   xb_valid_o   - per-output flit present this cycle
module switch_allocator
  import noc_params::*;
#(
  parameter int unsigned PORT_NUM  = noc_params::PORT_NUM,
  parameter int unsigned PORT_SIZE = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 request_i  [PORT_NUM],
  input  port_t                out_port_i [PORT_NUM],
  input  logic                 is_tail_i  [PORT_NUM],
  input  logic                 on_off_i   [PORT_NUM],
  output logic                 valid_o    [PORT_NUM],
  output logic [PORT_SIZE-1:0] xb_sel_o   [PORT_NUM],
  output logic                 xb_valid_o [PORT_NUM]
);

  logic [PORT_NUM-1:0]  w_req       [PORT_NUM];
  logic [PORT_NUM-1:0]  w_arb_req   [PORT_NUM];
  logic                 w_update    [PORT_NUM];
  logic [PORT_NUM-1:0]  w_grant     [PORT_NUM];
  logic [PORT_SIZE-1:0] w_grant_idx [PORT_NUM];

  for (genvar o = 0; o < PORT_NUM; o++) begin : g_out
    // Eligibility folded into the request so a blocked output neither grants
    // nor moves its pointer/lock.
    for (genvar i = 0; i < PORT_NUM; i++) begin : g_req
      assign w_req[o][i] = request_i[i] && (32'(out_port_i[i]) == o) && on_off_i[o];
    end

`ifdef SA_WORMHOLE_LOCK_EN
    logic                 r_locked;
    logic [PORT_SIZE-1:0] r_owner;
    logic                 w_owner_tail;
    logic                 w_win_tail;

    assign w_owner_tail = is_tail_i[r_owner];
    assign w_win_tail   = is_tail_i[w_grant_idx[o]];

    // While locked only the owner can reach the arbiter, so the search
    // degenerates to the owner and a tail grant moves the pointer to owner+1.
    assign w_arb_req[o] = r_locked ? (w_req[o] & (PORT_NUM'(1) << r_owner)) : w_req[o];
    assign w_update[o]  = !r_locked || w_owner_tail;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_locked <= 1'b0;
        r_owner  <= '0;
      end else if (|w_grant[o]) begin
        if (r_locked) begin
          if (w_owner_tail) r_locked <= 1'b0;
        end else if (!w_win_tail) begin
          r_locked <= 1'b1;
          r_owner  <= w_grant_idx[o];
        end
      end
    end
`else
    assign w_arb_req[o] = w_req[o];
    assign w_update[o]  = 1'b1;
`endif

    round_robin_arbiter #(
      .N    (PORT_NUM),
      .IdxW (PORT_SIZE)
    ) u_arb (
      .clk         (clk),
      .rst         (rst),
      .request_i   (w_arb_req[o]),
      .update_i    (w_update[o]),
      .grant_o     (w_grant[o]),
      .grant_idx_o (w_grant_idx[o])
    );
  end

`ifndef SA_WORMHOLE_LOCK_EN
  logic w_unused_tail;
  always_comb begin
    w_unused_tail = 1'b0;
    for (int i = 0; i < PORT_NUM; i++) w_unused_tail = w_unused_tail ^ is_tail_i[i];
  end
`endif

  always_comb begin
    for (int i = 0; i < PORT_NUM; i++) begin
      valid_o[i] = 1'b0;
      for (int o = 0; o < PORT_NUM; o++) valid_o[i] = valid_o[i] | w_grant[o][i];
      if (rst) valid_o[i] = 1'b0;
    end
    for (int o = 0; o < PORT_NUM; o++) begin
      xb_valid_o[o] = !rst && (|w_grant[o]);
      xb_sel_o[o]   = xb_valid_o[o] ? w_grant_idx[o] : '0;
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
module tb_switch_allocator;
  import noc_params::*;

  localparam int N = PORT_NUM;
  localparam int W = PORT_W;

  logic  clk = 1'b0;
  logic  rst;
  logic  request  [N];
  port_t out_port [N];
  logic  is_tail  [N];
  logic  on_off   [N];
  logic  valid    [N];
  port_t xb_sel   [N];
  logic  xb_valid [N];

  always #5 clk = ~clk;

  switch_allocator dut (
    .clk        (clk),
    .rst        (rst),
    .request_i  (request),
    .out_port_i (out_port),
    .is_tail_i  (is_tail),
    .on_off_i   (on_off),
    .valid_o    (valid),
    .xb_sel_o   (xb_sel),
    .xb_valid_o (xb_valid)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: per-output pointer and lock, winner by circular distance.
  int m_ptr    [N];
  bit m_locked [N];
  int m_owner  [N];
  int m_win    [N];

  logic [N-1:0]   s_valid;
  logic [N-1:0]   s_xbv;
  logic [N*W-1:0] s_sel;

  task automatic model_eval();
    int best_d, d;
    for (int o = 0; o < N; o++) begin
      m_win[o] = -1;
      if (rst || !on_off[o]) continue;
`ifdef SA_WORMHOLE_LOCK_EN
      if (m_locked[o]) begin
        if (request[m_owner[o]] && int'(out_port[m_owner[o]]) == o) m_win[o] = m_owner[o];
        continue;
      end
`endif
      best_d = N;
      for (int i = 0; i < N; i++) begin
        if (request[i] && int'(out_port[i]) == o) begin
          d = (i - m_ptr[o] + N) % N;
          if (d < best_d) begin
            best_d   = d;
            m_win[o] = i;
          end
        end
      end
    end
  endtask

  task automatic model_update();
    int w;
    for (int o = 0; o < N; o++) begin
      if (rst) begin
        m_ptr[o]    = 0;
        m_locked[o] = 1'b0;
        m_owner[o]  = 0;
        continue;
      end
      w = m_win[o];
      if (w < 0) continue;
`ifdef SA_WORMHOLE_LOCK_EN
      if (m_locked[o]) begin
        if (is_tail[w]) begin
          m_locked[o] = 1'b0;
          m_ptr[o]    = (w + 1) % N;
        end
      end else begin
        m_ptr[o] = (w + 1) % N;
        if (!is_tail[w]) begin
          m_locked[o] = 1'b1;
          m_owner[o]  = w;
        end
      end
`else
      m_ptr[o] = (w + 1) % N;
`endif
    end
  endtask

  // One cycle: sample at negedge, compare to model, advance model at posedge.
  task automatic step(input string tag);
    logic [N-1:0]   e_valid;
    logic [N-1:0]   e_xbv;
    logic [N*W-1:0] e_sel;
    @(negedge clk);
    model_eval();
    e_valid = '0;
    e_xbv   = '0;
    e_sel   = '0;
    for (int o = 0; o < N; o++) begin
      s_valid[o]       = valid[o];
      s_xbv[o]         = xb_valid[o];
      s_sel[o*W +: W]  = xb_sel[o];
      if (m_win[o] >= 0) begin
        e_valid[m_win[o]] = 1'b1;
        e_xbv[o]          = 1'b1;
        e_sel[o*W +: W]   = W'(m_win[o]);
      end
    end
    check_eq({tag, "/valid"}, 32'(s_valid), 32'(e_valid));
    check_eq({tag, "/xb_valid"}, 32'(s_xbv), 32'(e_xbv));
    check_eq({tag, "/xb_sel"}, 32'(s_sel), 32'(e_sel));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) begin
      request[i]  = 1'b0;
      out_port[i] = '0;
      is_tail[i]  = 1'b1;
      on_off[i]   = 1'b1;
    end
  endtask

  task automatic req(input int i, input int o, input bit tail);
    request[i]  = 1'b1;
    out_port[i] = W'(o);
    is_tail[i]  = tail;
  endtask

  initial begin
    for (int o = 0; o < N; o++) begin
      m_ptr[o] = 0; m_locked[o] = 1'b0; m_owner[o] = 0; m_win[o] = -1;
    end

    // Reset with everyone requesting: outputs forced low.
    clear_inputs();
    rst = 1'b1;
    for (int i = 0; i < N; i++) req(i, i, 1'b1);
    step("reset_hold");
    check_eq("reset_xbv_zero", 32'(s_xbv), 32'd0);
    rst = 1'b0;
    clear_inputs();
    step("reset_release");

    // Fairness on output 0.
    req(1, 0, 1'b1); req(2, 0, 1'b1); req(3, 0, 1'b1);
    step("fair1"); check_eq("fair1_sel", 32'(s_sel[W-1:0]), 32'd1);
    step("fair2"); check_eq("fair2_sel", 32'(s_sel[W-1:0]), 32'd2);
    step("fair3"); check_eq("fair3_sel", 32'(s_sel[W-1:0]), 32'd3);
    step("fair4"); check_eq("fair4_sel", 32'(s_sel[W-1:0]), 32'd1);
    check_eq("fair4_onehot", 32'(s_valid), 32'b00010);
    clear_inputs();

    // Pointer wrap on output 2.
    req(4, 2, 1'b1);
    step("wrap1"); check_eq("wrap1_valid", 32'(s_valid), 32'b10000);
    req(0, 2, 1'b1);
    step("wrap2"); check_eq("wrap2_valid", 32'(s_valid), 32'b00001);
    clear_inputs();

    // Unknown port never granted.
    req(1, 6, 1'b1);
    step("unknown"); check_eq("unknown_valid", 32'(s_valid), 32'd0);
    clear_inputs();

    // Backpressure on output 3.
    req(2, 3, 1'b1);
    on_off[3] = 1'b0;
    step("bp_block"); check_eq("bp_block_valid", 32'(s_valid), 32'd0);
    on_off[3] = 1'b1;
    step("bp_open"); check_eq("bp_open_valid", 32'(s_valid), 32'b00100);
    clear_inputs();

    // Wormhole packet on output 1 competing with input 4.
    rst = 1'b1; step("lock_rst"); rst = 1'b0;
    req(0, 1, 1'b0); req(4, 1, 1'b1);
    step("lock_head"); check_eq("lock_head_valid", 32'(s_valid), 32'b00001);
    step("lock_body");
    request[0] = 1'b0;
    step("lock_bubble");
`ifdef SA_WORMHOLE_LOCK_EN
    check_eq("lock_bubble_valid", 32'(s_valid), 32'd0);
`endif
    req(0, 1, 1'b1);
    step("lock_tail");
`ifdef SA_WORMHOLE_LOCK_EN
    check_eq("lock_tail_valid", 32'(s_valid), 32'b00001);
`endif
    req(0, 1, 1'b0);
    step("lock_after"); check_eq("lock_after_valid", 32'(s_valid), 32'b10000);
    clear_inputs();

    // Parallel grants on distinct outputs.
    req(0, 1, 1'b1); req(2, 3, 1'b1);
    step("parallel");
    check_eq("parallel_valid", 32'(s_valid), 32'b00101);
    check_eq("parallel_xbv", 32'(s_xbv), 32'b01010);
    clear_inputs();

    // Reset during a locked packet releases the lock.
    req(0, 1, 1'b0);
    step("mid_head");
    req(4, 1, 1'b1);
    rst = 1'b1;
    step("mid_rst");
    rst = 1'b0;
    request[0] = 1'b0;
    step("mid_release"); check_eq("mid_release_valid", 32'(s_valid), 32'b10000);
    clear_inputs();

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < N; i++) begin
        request[i]  = ($urandom_range(0, 3) != 0);
        out_port[i] = W'($urandom_range(0, (1 << W) - 1));
        is_tail[i]  = ($urandom_range(0, 2) == 0);
        on_off[i]   = ($urandom_range(0, 4) != 0);
      end
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
